// File: rtl/dyser_cfg_pkg.sv
// Shared definitions for the DySER configuration loader.
// Holds the widths of a configuration word, the config-memory address and
// the word counter, plus the loader FSM state encoding.
package dyser_cfg_pkg;

  localparam int CFG_WIDTH      = 21;
  localparam int CFG_ADDR_WIDTH = 8;
  localparam int CFG_CNT_WIDTH  = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } cfg_state_e;

endpackage

// File: rtl/dyser_config_loader.sv
// dyser_config_loader
// Streams a configuration image from a small config memory into the DySER
// fabric. One read request is held in FETCH until the memory acknowledges;
// every acknowledged word is registered and strobed into DySER one cycle later.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   start, abort   load request (IDLE only) / load cancel (FETCH only)
//   base_addr      first memory address of the image
//   num_words      words to load (0 = empty load, straight to DONE)
//   mem_req/addr   read request and address toward the config memory
//   mem_ack/data   read completion, data valid in the ack cycle
//   config_bits/en word and strobe driven straight into DySER
//   busy, done     load in progress / one-cycle completion pulse
//   words_loaded   config_en strobes issued by the current or last load
//
// Handshake: a read transfers on any rising edge where mem_req=1 and
// mem_ack=1 (mem_data sampled at that edge); mem_req stays high and mem_addr
// stays stable until that edge. config_en has no back-pressure: DySER must
// accept config_bits on every cycle config_en=1.
module dyser_config_loader
  import dyser_cfg_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [CFG_ADDR_WIDTH-1:0] base_addr,
  input  logic [CFG_CNT_WIDTH-1:0]  num_words,
  output logic                      mem_req,
  output logic [CFG_ADDR_WIDTH-1:0] mem_addr,
  input  logic                      mem_ack,
  input  logic [CFG_WIDTH-1:0]      mem_data,
  output logic [CFG_WIDTH-1:0]      config_bits,
  output logic                      config_en,
  output logic                      busy,
  output logic                      done,
  output logic [CFG_CNT_WIDTH-1:0]  words_loaded
);

  cfg_state_e                state_q, state_d;
  logic [CFG_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CFG_CNT_WIDTH-1:0]  remaining_q, remaining_d;
  logic [CFG_CNT_WIDTH-1:0]  words_loaded_q, words_loaded_d;
  logic [CFG_WIDTH-1:0]      config_bits_q, config_bits_d;
  logic                      config_en_q, config_en_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      remaining_q    <= '0;
      words_loaded_q <= '0;
      config_bits_q  <= '0;
      config_en_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      remaining_q    <= remaining_d;
      words_loaded_q <= words_loaded_d;
      config_bits_q  <= config_bits_d;
      config_en_q    <= config_en_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    remaining_d    = remaining_q;
    words_loaded_d = words_loaded_q;
    config_bits_d  = config_bits_q;
    config_en_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          words_loaded_d = '0;
          if (num_words != '0) begin
            addr_d      = base_addr;
            remaining_d = num_words;
            state_d     = ST_FETCH;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_FETCH: begin
        // Abort wins over a same-cycle ack: that word is dropped.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (mem_ack) begin
          config_bits_d  = mem_data;
          config_en_d    = 1'b1;
          addr_d         = addr_q + 1'b1;  // wraps 0xFF -> 0x00
          remaining_d    = remaining_q - 1'b1;
          words_loaded_d = words_loaded_q + 1'b1;
          // Entering DONE here lines the done pulse up with the last strobe.
          if (remaining_q == 5'd1) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mem_req      = (state_q == ST_FETCH);
  assign busy         = (state_q == ST_FETCH);
  assign done         = (state_q == ST_DONE);
  assign mem_addr     = addr_q;
  assign config_bits  = config_bits_q;
  assign config_en    = config_en_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_dyser_config_loader.sv
// Bench for dyser_config_loader: table of load scenarios run through one
// cycle-by-cycle model, plus hand-written reset sequences.
module tb_dyser_config_loader;
  import dyser_cfg_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [4:0]  num_words = '0;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack = 1'b0;
  logic [20:0] mem_data = '0;
  logic [20:0] config_bits;
  logic        config_en;
  logic        busy;
  logic        done;
  logic [4:0]  words_loaded;

  always #5 clk = ~clk;

  dyser_config_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .base_addr    (base_addr),
    .num_words    (num_words),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_data     (mem_data),
    .config_bits  (config_bits),
    .config_en    (config_en),
    .busy         (busy),
    .done         (done),
    .words_loaded (words_loaded)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [20:0] mem [256];
  logic [20:0] exp_q [$];
  logic [20:0] cb_model = '0;
  logic [4:0]  wl_model = '0;

  typedef struct {
    logic [7:0] base;
    logic [4:0] num;
    int         period;      // ack on every period-th FETCH cycle
    int         abort_k;     // abort together with this ack number (0 = none)
    int         restart;     // FETCH cycle index for an ignored start (0 = none)
    int         exp_loaded;
    int         exp_done;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".config_bits"},  32'(config_bits),  0);
    chk({tag, ".config_en"},    32'(config_en),    0);
    chk({tag, ".mem_req"},      32'(mem_req),      0);
    chk({tag, ".mem_addr"},     32'(mem_addr),     0);
    chk({tag, ".busy"},         32'(busy),         0);
    chk({tag, ".done"},         32'(done),         0);
    chk({tag, ".words_loaded"}, 32'(words_loaded), 0);
  endtask

  // ---------------- driver + per-cycle model ----------------
  task automatic run_vec(input vec_t v, input int idx);
    int   fetch_n, acks, idle_n, done_n, strobes, cyc;
    logic pend_en, exp_fetch, exp_done;
    logic [7:0] exp_addr;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    start = 1'b1; base_addr = v.base; num_words = v.num;
    wl_model  = '0;
    exp_fetch = (v.num != 0);
    exp_done  = (v.num == 0);
    pend_en   = 1'b0;
    fetch_n = 0; acks = 0; idle_n = 0; done_n = 0; strobes = 0;
    exp_q.delete();
    for (cyc = 0; cyc < 300 && idle_n < 3; cyc++) begin
      @(negedge clk);
      start = 1'b0; mem_ack = 1'b0; abort = 1'b0; mem_data = 21'($urandom);
      // outputs here reflect the last rising edge
      chk({tag, ".config_en"},    32'(config_en),    32'(pend_en));
      chk({tag, ".done"},         32'(done),         32'(exp_done));
      chk({tag, ".mem_req"},      32'(mem_req),      32'(exp_fetch));
      chk({tag, ".busy"},         32'(busy),         32'(exp_fetch));
      chk({tag, ".words_loaded"}, 32'(words_loaded), 32'(wl_model));
      if (config_en && exp_q.size() > 0)
        chk({tag, ".config_word"}, 32'(config_bits), 32'(exp_q.pop_front()));
      else
        chk({tag, ".config_hold"}, 32'(config_bits), 32'(cb_model));
      if (config_en) strobes++;
      if (done) done_n++;
      pend_en = 1'b0; exp_done = 1'b0;
      if (exp_fetch) begin
        exp_addr = 8'(v.base + acks);
        chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(exp_addr));
        if (v.restart != 0 && fetch_n == v.restart) begin
          start = 1'b1; base_addr = 8'h00; num_words = 5'd9;
        end
        if ((fetch_n % v.period) == v.period - 1) begin
          mem_ack  = 1'b1;
          mem_data = mem[exp_addr];
          if (v.abort_k != 0 && acks + 1 == v.abort_k) begin
            abort = 1'b1;
            exp_fetch = 1'b0;
          end else begin
            acks++;
            pend_en  = 1'b1;
            cb_model = mem[exp_addr];
            exp_q.push_back(mem[exp_addr]);
            wl_model = wl_model + 5'd1;
            if (acks == v.num) begin
              exp_fetch = 1'b0;
              exp_done  = 1'b1;
            end
          end
        end
        fetch_n++;
      end else begin
        idle_n++;
      end
    end
    chk({tag, ".timeout"}, 32'(idle_n >= 3), 1);
    chk({tag, ".final_words_loaded"}, 32'(words_loaded), 32'(v.exp_loaded));
    chk({tag, ".strobe_count"}, 32'(strobes), 32'(v.exp_loaded));
    chk({tag, ".done_count"}, 32'(done_n), 32'(v.exp_done));
    chk({tag, ".final_busy"}, 32'(busy), 0);
    start = 1'b0; mem_ack = 1'b0; abort = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    logic [20:0] image [17];
    image = '{21'h000000, 21'h000080, 21'h040980, 21'h1A2B3C, 21'h0F0F0F,
              21'h155555, 21'h0AAAAA, 21'h100001, 21'h003C00, 21'h1FFFFF,
              21'h012345, 21'h06789A, 21'h0BCDEF, 21'h111111, 21'h022222,
              21'h0C0C0C, 21'h000010};
    for (int i = 0; i < 256; i++) mem[i] = 21'((i * 32'h1357) ^ 32'h0A5A5);
    for (int i = 0; i < 17; i++) mem[8'h10 + i] = image[i];

    //            base   num  per abort rst loaded done
    vecs[0] = '{8'h10, 5'd17, 1, 0, 0, 17, 1};  // full image, back-to-back
    vecs[1] = '{8'h20, 5'd3,  3, 0, 0, 3,  1};  // ack every third FETCH cycle
    vecs[2] = '{8'hFE, 5'd4,  1, 0, 0, 4,  1};  // address wrap
    vecs[3] = '{8'h00, 5'd0,  1, 0, 0, 0,  1};  // empty load
    vecs[4] = '{8'h30, 5'd5,  1, 2, 0, 1,  0};  // abort with 2nd ack
    vecs[5] = '{8'h50, 5'd2,  2, 0, 0, 2,  1};  // start after abort
    vecs[6] = '{8'h60, 5'd4,  3, 0, 2, 4,  1};  // start during FETCH ignored

    // reset state
    #3;
    chk_all_zero("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    // abort while idle does nothing
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort.busy", 32'(busy), 0);
    chk("idle_abort.done", 32'(done), 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // reset mid-load while a strobe is high
    @(negedge clk);
    start = 1'b1; base_addr = 8'h40; num_words = 5'd4;
    @(negedge clk);
    start = 1'b0;
    chk("mid_rst.mem_req", 32'(mem_req), 1);
    mem_ack = 1'b1; mem_data = mem[8'h40];
    @(negedge clk);
    mem_ack = 1'b0;
    chk("mid_rst.config_en", 32'(config_en), 1);
    chk("mid_rst.config_bits", 32'(config_bits), 32'(mem[8'h40]));
    #2 rst = 1'b1;
    #1 chk_all_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    cb_model = '0; wl_model = '0;
    @(negedge clk);
    chk("post_rst.mem_req", 32'(mem_req), 0);
    chk("post_rst.done", 32'(done), 0);

    run_vec(vecs[6], 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
